// File: rtl/mini_io_pkg.sv
// Shared constants for the memory-mapped IO block: register addresses and
// the default transmit queue depth.
package mini_io_pkg;

    localparam logic [15:0] ADDR_LED    = 16'hC000;
    localparam logic [15:0] ADDR_SW     = 16'hC001;
    localparam logic [15:0] ADDR_UART   = 16'hC004;
    localparam logic [15:0] ADDR_STATUS = 16'hC005;

    localparam int TX_DEPTH_DEFAULT = 4;

    // The status register only has three bits for the queue level.
    function automatic logic [2:0] sat_count(input logic [4:0] c);
        return (c > 5'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte-wide transmit queue between the processor data port and the UART.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [4:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == 5'(DEPTH));
    assign empty   = (count_q == 5'd0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped IO controller: LEDs, synchronized switches, UART TX queue,
// single-byte UART RX holding register and a status word.
module mmio_ctrl
    import mini_io_pkg::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        stall,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack
);

    logic        io_sel, rd_req;
    logic        hit_led, hit_sw, hit_uart, hit_status;
    logic        tx_full, tx_empty, tx_push, tx_pop;
    logic [4:0]  tx_count;
    logic [7:0]  tx_head;
    logic        rx_read;
    logic [15:0] rd_value;

    logic [9:0]  led_q, led_d;
    logic [9:0]  sw_meta_q, sw_sync_q;
    logic [15:0] rdata_q, rdata_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_hold_q, rx_hold_d;

    logic [5:0]  unused_wdata;
    assign unused_wdata = wdata[15:10];

    assign io_sel     = (addr[15:14] == 2'b11);
    assign hit_led    = io_sel && (addr == ADDR_LED);
    assign hit_sw     = io_sel && (addr == ADDR_SW);
    assign hit_uart   = io_sel && (addr == ADDR_UART);
    assign hit_status = io_sel && (addr == ADDR_STATUS);

    // A simultaneous read and write is served as a write only.
    assign rd_req = re & ~we;

    assign stall    = RST_n & we & hit_uart & tx_full;
    assign tx_push  = RST_n & we & hit_uart & ~tx_full;
    assign tx_valid = RST_n & ~tx_empty;
    assign tx_data  = tx_head;
    assign tx_pop   = tx_valid & tx_ready;

    // Reading the holding byte frees it, so a new byte may land in the same cycle.
    assign rx_read = rd_req & hit_uart & rx_full_q;
    assign rx_ack  = RST_n & rx_valid & (~rx_full_q | rx_read);

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .RST_n (RST_n),
        .push  (tx_push),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        rd_value = 16'h0000;
        if (hit_led)    rd_value = {6'h00, led_q};
        if (hit_sw)     rd_value = {6'h00, sw_sync_q};
        if (hit_uart)   rd_value = rx_full_q ? {8'h00, rx_hold_q} : 16'h0000;
        if (hit_status) rd_value = {10'h000, sat_count(tx_count), tx_empty, tx_full, rx_full_q};
    end

    always_comb begin
        led_d     = led_q;
        rdata_d   = rdata_q;
        rx_full_d = rx_full_q;
        rx_hold_d = rx_hold_q;
        if (we && hit_led) led_d = wdata[9:0];
        if (rd_req)        rdata_d = rd_value;
        if (rx_ack) begin
            rx_full_d = 1'b1;
            rx_hold_d = rx_data;
        end else if (rx_read) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= '0;
            rx_full_q <= 1'b0;
            rx_hold_q <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
            rx_full_q <= rx_full_d;
            rx_hold_q <= rx_hold_d;
        end
    end

    assign LEDR  = led_q;
    assign rdata = rdata_q;

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port RST_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports addr  in  16, wdata  in  16, we  in  1, re  in  1: processor data-port request, one cycle per request.
REQ-005 SHALL have port rdata  out  16  read data, registered.
REQ-006 SHALL have port stall  out  1  processor must hold the request while high.
REQ-007 SHALL have ports SW  in  10 (asynchronous switches) and LEDR  out  10 (LED drive).
REQ-008 SHALL have ports tx_data  out  8, tx_valid  out  1, tx_ready  in  1: byte stream to UART transmitter.
REQ-009 SHALL have ports rx_data  in  8, rx_valid  in  1, rx_ack  out  1: byte stream from UART receiver.

Function
REQ-010 SHALL decode an IO access when addr[15:14]==2'b11; other addresses: writes ignored, rdata 0x0000.
REQ-011 SHALL map 0xC000 LED (R/W, wdata[9:0]), 0xC001 SW (RO), 0xC004 UART data (W enqueues TX, R dequeues RX), 0xC005 status (RO); other IO addresses read 0x0000, writes ignored.
REQ-012 SHALL update LEDR in the cycle after an accepted write to 0xC000.
REQ-013 SHALL pass SW through a 2-flop synchronizer; a 0xC001 read returns {6'h0, synchronized SW}.
REQ-014 SHALL present rdata in the cycle after re is sampled high with stall low; rdata holds its value otherwise.
REQ-015 SHALL drive stall combinationally high when we targets 0xC004 and the TX FIFO is full; otherwise stall is low.
REQ-016 SHALL enqueue wdata[7:0] into the TX FIFO on a write to 0xC004 with stall low.
REQ-017 SHALL drive tx_valid = FIFO non-empty and tx_data = head entry; pop when tx_valid && tx_ready.
REQ-018 SHALL keep the FIFO count unchanged when push and pop occur in the same cycle; wrap pointers modulo TX_DEPTH.
REQ-019 SHALL hold one RX byte in a holding register with an rx_full flag.
REQ-020 SHALL capture rx_data and pulse rx_ack for one cycle when rx_valid is high and (rx_full low or the holding byte is read this cycle).
REQ-021 SHALL return {8'h00, holding byte} and clear rx_full on a 0xC004 read when rx_full is high; when rx_full is low return 0x0000 with no stall.
REQ-022 SHALL leave rx_full set (new byte replaces old) when a read and capture coincide.
REQ-023 SHALL return status {10'h0, count[2:0], tx_empty, tx_full, rx_full} (bits 5..0), count saturating display at 7.
REQ-024 SHALL treat we and re high together as a write only.

Reset
REQ-025 SHALL, on RST_n low at posedge, clear LEDR, rdata, FIFO pointers/count, rx_full, holding byte and synchronizer flops to 0.
REQ-026 SHALL hold tx_valid, rx_ack, stall low during reset; reset mid-transfer discards all queued TX bytes.

Structure
REQ-027 SHALL place IO address constants (LED, SW, UART data, status) and default TX_DEPTH in shared package mini_io_pkg.
REQ-028 SHALL implement the TX queue as sub-module io_tx_fifo (push, pop, full, empty, count, head data).
REQ-029 SHALL be 120-400 lines of RTL with no latches and no multi-driven nets.

Verification
REQ-030 SHALL test: SW=10'h2A5, wait 3 cycles, read 0xC001 -> rdata=0x02A5 next cycle.
REQ-031 SHALL test: write 0x0003 to 0xC000 -> LEDR=10'h003 one cycle later; read 0xC000 -> 0x0003.
REQ-032 SHALL test: tx_ready=0, write 0x41,0x42,0x43,0x44 then 0x45 -> stall high on fifth; raise tx_ready -> bytes 41..45 emitted in order, stall drops after first pop.
REQ-033 SHALL test: rx_valid with 0x5A -> rx_ack one pulse, status bit0=1; read 0xC004 -> 0x005A, status bit0=0.
REQ-034 SHALL test: read 0xC004 with no RX byte -> 0x0000, stall never asserted; read 0x8000 -> 0x0000.
REQ-035 SHALL test: two TX bytes queued, assert RST_n=0 one cycle -> tx_valid=0, status=0x0004, LEDR=0.
